// File: rtl/fixed_accum.sv
// Saturating Q32.10 vector accumulator: sums elements until in_last, then holds
// the sum, element count and sticky saturation flag until downstream accepts it.
module fixed_accum #(
    parameter int DATA_W = 43,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [DATA_W-1:0] DATA_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_POS_LIM = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DATA_NEG_LIM = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
    localparam logic signed [DATA_W:0] SUM_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] SUM_MIN = {2'b11, {(DATA_W-2){1'b0}}, 1'b1};

    state_t              state;
    logic [DATA_W-1:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic                sat;

    logic [DATA_W-1:0]   d_eff;
    logic signed [DATA_W:0] sum;
    logic [DATA_W-1:0]   acc_next;
    logic                add_sat;
    logic [CNT_W-1:0]    cnt_next;

    // The most negative code is folded onto -MAX so the range stays symmetric.
    always_comb begin
        add_sat  = 1'b0;
        d_eff    = in_data;
        if (in_data == DATA_MIN) begin
            d_eff   = DATA_NEG_LIM;
            add_sat = 1'b1;
        end
        sum      = {acc[DATA_W-1], acc} + {d_eff[DATA_W-1], d_eff};
        acc_next = sum[DATA_W-1:0];
        if (sum > SUM_MAX) begin
            acc_next = DATA_POS_LIM;
            add_sat  = 1'b1;
        end else if (sum < SUM_MIN) begin
            acc_next = DATA_NEG_LIM;
            add_sat  = 1'b1;
        end
        cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        sat <= sat | add_sat;
                        if (in_last)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

endmodule

// File: doc/fixed_accum.md
FIXED_ACCUM -- requirements
Module: fixed_accum

Interface
REQ-001 Parameter: DATA_W, default 43, width of the signed two's-complement fixed-point sample (Q32.10: 1 sign, 32 integer, 10 fraction bits).
REQ-002 Parameter: CNT_W, default 16, width of the element counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  in_data/in_last are valid this cycle.
REQ-006 Port: in_data  input  DATA_W  signed fixed-point addend.
REQ-007 Port: in_last  input  1  marks the final element of the current vector.
REQ-008 Port: in_ready  output  1  block can accept an element this cycle.
REQ-009 Port: out_valid  output  1  out_data/out_count/out_sat hold a completed sum.
REQ-010 Port: out_ready  input  1  downstream (fixed2float) accepts the result.
REQ-011 Port: out_data  output  DATA_W  saturated signed sum, drives fixed2float fixed_in directly.
REQ-012 Port: out_count  output  CNT_W  number of elements accepted into this sum.
REQ-013 Port: out_sat  output  1  sticky flag: at least one add in this vector saturated.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-015 States: ACCUM (collecting elements) and HOLD (result presented); in_ready = 1 in ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-016 On each input transfer the accumulator updates to sat(acc + in_data), computed at DATA_W+1 bits and clamped to DATA_W bits.
REQ-017 Clamp limits: positive overflow -> +(2^(DATA_W-1)-1); negative overflow -> -(2^(DATA_W-1)-1); the value -2^(DATA_W-1) never appears on out_data, even when presented on in_data (it is treated as -(2^(DATA_W-1)-1)).
REQ-018 Any clamp, including the in_data substitution of REQ-017, sets the sticky sat flag for the current vector.
REQ-019 Element counter increments by 1 per input transfer and saturates at 2^CNT_W-1 without wrapping; counter saturation does not set out_sat.
REQ-020 An input transfer with in_last = 1 moves ACCUM -> HOLD; out_valid rises on the next cycle (latency 1) with out_data including that element.
REQ-021 In HOLD, out_data, out_count and out_sat remain stable until the output transfer.
REQ-022 On the output transfer: HOLD -> ACCUM; accumulator, counter and sat flag clear to 0 on that edge; in_ready is 1 in the following cycle.
REQ-023 in_data/in_last presented while in_ready = 0 are ignored with no state change.
REQ-024 A single-element vector (first element with in_last = 1) yields out_data = sat(in_data), out_count = 1.
REQ-025 A vector with no in_last never produces output; the accumulator keeps saturating and the counter holds at its maximum.
REQ-026 out_data, out_count and out_sat are driven directly from registers; there is no combinational path from in_* to out_*.

Reset
REQ-027 While reset = 1 at a clock edge: state = ACCUM, accumulator = 0, counter = 0, sat flag = 0.
REQ-028 After reset: out_valid = 0, out_data = 0, out_count = 0, out_sat = 0, in_ready = 1.
REQ-029 Reset asserted mid-vector or in HOLD discards the partial or pending result; no output transfer occurs for it.

Verification
REQ-030 Sum: in_data 5.0 (0x1400), -2.25 (-0x900), 1.5 (0x600 with last); out_ready = 1 -> out_valid 1 cycle after last, out_data = 0x1100 (4.25), out_count = 3, out_sat = 0.
REQ-031 Positive saturation: 0x3FF_FFFF_FFFF then 1 (last) -> out_data = 0x3FF_FFFF_FFFF, out_sat = 1; the next vector 7 (last) -> out_data = 7, out_sat = 0.
REQ-032 Negative limit: single element 0x400_0000_0000 (last) -> out_data = 0x400_0000_0001, out_sat = 1.
REQ-033 Backpressure: out_ready = 0 for 10 cycles after result with in_valid held 1 -> in_ready = 0, outputs stable, no element accepted; out_ready = 1 -> one transfer, in_ready = 1 next cycle.
REQ-034 Reset mid-vector: 3 elements accepted, reset pulse 1 cycle, then 2 (last) -> out_data = 2, out_count = 1.
REQ-035 Random: 10^5 random in_valid/out_ready patterns versus a saturating reference sum -> every out_data/out_count/out_sat matches, no result lost or duplicated.
